// File: rtl/sync_fifo_gen.sv
// sync_fifo_gen -- parametrised single-clock FIFO used as the literal/match
// byte buffer between LZ4 decoder stages.
//
// Arbitrary DEPTH (pointers wrap at DEPTH-1, not at 2**ADDR_W), standard or
// first-word-fall-through read, programmable almost-full/almost-empty levels,
// sticky overflow/underflow, synchronous flush.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   flush           synchronous clear of contents (overrides wr_en/rd_en)
//   wr_en, data_in  write request and data
//   rd_en           read request (FWFT: pop head)
//   af_thresh       almst_full  when count >= af_thresh
//   ae_thresh       almst_empty when count <= ae_thresh
//   clr_err         clear ovf/udf (a same-cycle set wins)
//   data_out        read data; data_valid marks it valid
//   data_count      occupancy; empty/full/almst_* registered alongside it
//   ovf, udf        sticky: write refused / read refused
module sync_fifo_gen #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter bit FWFT   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   af_thresh,
  input  logic [ADDR_W:0]   ae_thresh,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [ADDR_W:0]   data_count,
  output logic              empty,
  output logic              full,
  output logic              almst_empty,
  output logic              almst_full,
  output logic              ovf,
  output logic              udf
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d, full_q, full_d;
  logic              ae_q, ae_d, af_q, af_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              rd_acc, wr_acc;

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

  // No read bypass: a read on empty is refused even with a same-cycle write.
  // A write on full is accepted when a read frees a slot in the same cycle.
  assign rd_acc = rd_en & ~empty_q & ~flush;
  assign wr_acc = wr_en & (~full_q | rd_acc) & ~flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;

    // Flags track count_d so they move on the same edge as data_count.
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_FULL);
    ae_d    = (count_d <= ae_thresh);
    af_d    = (count_d >= af_thresh);

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      empty_d  = 1'b1;
      full_d   = 1'b0;
      ae_d     = 1'b1;
      af_d     = 1'b0;
    end

    // Set has priority over clear; flush neither sets nor clears.
    ovf_d = (~flush & wr_en & ~wr_acc) | (ovf_q & ~clr_err);
    udf_d = (~flush & rd_en & empty_q) | (udf_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      // Head shown combinationally; forced to 0 while empty so stale or
      // uninitialised storage never reaches the port.
      assign data_out   = empty_q ? '0 : mem[rd_ptr_q];
      assign data_valid = ~empty_q;
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      logic              dvld_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dout_q <= '0;
          dvld_q <= 1'b0;
        end else if (flush) begin
          dout_q <= '0;
          dvld_q <= 1'b0;
        end else begin
          dvld_q <= rd_acc;
          if (rd_acc) dout_q <= mem[rd_ptr_q];
        end
      end

      assign data_out   = dout_q;
      assign data_valid = dvld_q;
    end
  endgenerate

  assign data_count  = count_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almst_empty = ae_q;
  assign almst_full  = af_q;
  assign ovf         = ovf_q;
  assign udf         = udf_q;

endmodule

// File: tb/tb_sync_fifo_gen.sv
// Directed bench for sync_fifo_gen: DEPTH=5 standard-read instance and a
// DEPTH=5 FWFT instance driven by the same stimulus.
module tb_sync_fifo_gen;
  localparam int DW = 8;
  localparam int DP = 5;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          rd_en = 1'b0;
  logic [AW:0]   af_thresh = 4'd4;
  logic [AW:0]   ae_thresh = 4'd1;
  logic          clr_err = 1'b0;

  logic [DW-1:0] dout, fw_dout;
  logic          dvld, fw_dvld;
  logic [AW:0]   cnt, fw_cnt;
  logic          emp, fw_emp, ful, fw_ful, ae, fw_ae, af, fw_af;
  logic          ovf, fw_ovf, udf, fw_udf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sync_fifo_gen #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .FWFT(1'b0)) u_std (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .af_thresh(af_thresh), .ae_thresh(ae_thresh), .clr_err(clr_err),
    .data_out(dout), .data_valid(dvld), .data_count(cnt), .empty(emp), .full(ful),
    .almst_empty(ae), .almst_full(af), .ovf(ovf), .udf(udf)
  );

  sync_fifo_gen #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .FWFT(1'b1)) u_fw (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .af_thresh(af_thresh), .ae_thresh(ae_thresh), .clr_err(clr_err),
    .data_out(fw_dout), .data_valid(fw_dvld), .data_count(fw_cnt), .empty(fw_emp),
    .full(fw_ful), .almst_empty(fw_ae), .almst_full(fw_af), .ovf(fw_ovf), .udf(fw_udf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, then land 1 time unit after the edge.
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- reset state ----
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_flags", {emp, ful, ae, af, ovf, udf, dvld}, 7'b1010000);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_fw", {fw_dvld, fw_dout}, 0);
    reset = 1'b0;

    // ---- 1: fill to full, overflow, drain, underflow; thresholds 4/1 ----
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'(8'h11 + i), 1'b0);
      chk($sformatf("fill_cnt%0d", i + 1), 32'(cnt), 32'(i + 1));
      chk($sformatf("fill_ae%0d", i + 1), 32'(ae), 32'(i + 1 <= 1));
      chk($sformatf("fill_af%0d", i + 1), 32'(af), 32'(i + 1 >= 4));
      if (i == 0) chk("fw_first", {fw_dvld, fw_dout}, {1'b1, 8'h11});
    end
    chk("full5", {ful, emp}, 2'b10);
    cyc(1'b1, 8'h66, 1'b0);
    chk("ovf_set", {ovf, 4'(cnt)}, {1'b1, 4'd5});
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk($sformatf("rd%0d", i), {dvld, dout}, {1'b1, 8'(8'h11 + i)});
      if (i < 4) chk($sformatf("fw_rd%0d", i), 32'(fw_dout), 32'(8'h12 + i));
    end
    chk("drained", {emp, 4'(cnt), fw_dvld}, {1'b1, 4'd0, 1'b0});
    cyc(1'b0, 8'h00, 1'b1);
    chk("udf_set", {udf, dvld, dout}, {1'b1, 1'b0, 8'h15});
    clr_err = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    clr_err = 1'b0;
    chk("clr_err", {ovf, udf}, 2'b00);

    // ---- 2: write 3 / read 3, pointers wrap at DEPTH-1 ----
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h20 + r * 3 + i), 1'b0);
      for (int i = 0; i < 3; i++) begin
        cyc(1'b0, 8'h00, 1'b1);
        chk($sformatf("wrap_r%0d_%0d", r, i), 32'(dout), 32'(8'h20 + r * 3 + i));
      end
      chk($sformatf("wrap_cnt%0d", r), 32'(cnt), 0);
    end

    // ---- 3: simultaneous read/write at full and at empty ----
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h31 + i), 1'b0);
    cyc(1'b1, 8'h36, 1'b1);
    chk("full_rw", {ful, ovf, dvld, 4'(cnt), dout}, {1'b1, 1'b0, 1'b1, 4'd5, 8'h31});
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk($sformatf("full_rw_rd%0d", i), 32'(dout), 32'(8'h32 + i));
    end
    cyc(1'b1, 8'h40, 1'b1);
    chk("empty_rw", {4'(cnt), udf, dvld, emp}, {4'd1, 1'b1, 1'b0, 1'b0});
    cyc(1'b0, 8'h00, 1'b1);
    chk("empty_rw_rd", {dvld, dout}, {1'b1, 8'h40});
    clr_err = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    clr_err = 1'b0;

    // ---- 4: FWFT write to empty, then pop ----
    cyc(1'b1, 8'hA5, 1'b0);
    chk("fw_wr", {fw_dvld, fw_dout}, {1'b1, 8'hA5});
    cyc(1'b0, 8'h00, 1'b1);
    chk("fw_pop", {fw_emp, fw_dvld}, 2'b10);

    // ---- 5: threshold change reflected one edge later ----
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h51 + i), 1'b0);
    chk("af_at3", {af, ae}, 2'b00);
    af_thresh = 4'd2;
    cyc(1'b0, 8'h00, 1'b0);
    chk("af_thr2", 32'(af), 1);
    af_thresh = 4'd4;

    // ---- 6: flush beats write, clr_err vs set, async reset ----
    flush = 1'b1;
    cyc(1'b1, 8'h77, 1'b0);
    flush = 1'b0;
    chk("flush", {4'(cnt), emp, af, ovf, dvld, dout}, {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    clr_err = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);
    clr_err = 1'b0;
    chk("set_wins", 32'(udf), 1);
    cyc(1'b1, 8'h71, 1'b0);
    cyc(1'b1, 8'h72, 1'b0);
    chk("burst_cnt", 32'(cnt), 2);
    #3 reset = 1'b1;
    #1;
    chk("rst_mid", {4'(cnt), emp, ful, ae, af, ovf, udf, dvld, dout},
        {4'd0, 7'b1010000, 8'h00});
    chk("rst_mid_fw", {fw_dvld, fw_dout}, 0);
    af_thresh = 4'd0;
    wr_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("af_zero", {af, ae, emp}, 3'b111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end
endmodule
